// File: rtl/hist_pkg.sv
// Shared definitions for the histogram readout path: sweep FSM encoding and
// width helpers for the count-sum and index-weighted-sum datapaths.
package hist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Width of a cumulative count over all 2^bits bins.
    function automatic int sum_width(input int bits, input int hist_bits);
        return hist_bits + bits;
    endfunction

    // Width of sum(i * count(i)) over all 2^bits bins.
    function automatic int mean_width(input int bits, input int hist_bits);
        return hist_bits + 2 * bits;
    endfunction

endpackage

// File: rtl/hist_thresh_find.sv
// Percentile bin search: latches the first bin index whose running cumulative
// count exceeds the threshold; reports N-1 when no bin ever does.
module hist_thresh_find #(
    parameter int BITS = 8,
    parameter int CW   = 26
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            valid,
    input  logic [BITS-1:0] bin_idx,
    input  logic [CW-1:0]   cum,
    input  logic [CW-1:0]   thresh,
    output logic [BITS-1:0] result
);

    logic            found_reg, found_next;
    logic [BITS-1:0] bin_reg, bin_next;

    always_comb begin
        found_next = found_reg;
        bin_next   = bin_reg;
        if (clear) begin
            found_next = 1'b0;
            bin_next   = '1;
        end else if (valid && !found_reg && (cum > thresh)) begin
            found_next = 1'b1;
            bin_next   = bin_idx;
        end
    end

    // The bin register idles at N-1, so the next-state view is the answer
    // including the bin being accumulated this cycle.
    assign result = bin_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found_reg <= 1'b0;
            bin_reg   <= '1;
        end else begin
            found_reg <= found_next;
            bin_reg   <= bin_next;
        end
    end

endmodule

// File: rtl/hist_reader.sv
// Histogram readout engine: sweeps all bins of hist_stat, forms total, low/high
// percentile bins and (with HIST_READER_MEAN_EN defined) the index-weighted sum.
module hist_reader
    import hist_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int HIST_BITS = 18
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [HIST_BITS+BITS-1:0]     cfg_lo_cnt,
    input  logic [HIST_BITS+BITS-1:0]     cfg_hi_cnt,
    output logic                          rd_en,
    output logic [BITS-1:0]               rd_addr,
    input  logic [HIST_BITS-1:0]          rd_data,
    output logic                          busy,
    output logic                          done,
    output logic [HIST_BITS+BITS-1:0]     total,
    output logic [BITS-1:0]               lo_bin,
    output logic [BITS-1:0]               hi_bin,
    output logic [HIST_BITS+2*BITS-1:0]   mean_sum
);

    localparam int CW = sum_width(BITS, HIST_BITS);
    localparam int MW = mean_width(BITS, HIST_BITS);

    state_t state_reg, state_next;

    logic            accept;
    logic [BITS-1:0] addr_reg;
    logic            valid_d_reg;
    logic [BITS-1:0] addr_d_reg;
    logic [CW-1:0]   cum_reg, cum_next;
    logic [CW-1:0]   thr_cfg   [2];
    logic [CW-1:0]   thr_reg   [2];
    logic [BITS-1:0] bin_result[2];
    logic [CW-1:0]   total_reg;
    logic [BITS-1:0] lo_bin_reg, hi_bin_reg;

    assign accept = (state_reg == ST_IDLE) && start;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_READ;
            ST_READ:  if (addr_reg == '1) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_reg)
            ST_READ:  begin rd_en = 1'b1; busy = 1'b1; end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  begin busy = 1'b1; done = 1'b1; end
            default:  ;
        endcase
    end

    // Read address counter parks on N-1 so rd_addr holds between sweeps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= '0;
        end else if (accept) begin
            addr_reg <= '0;
        end else if ((state_reg == ST_READ) && (addr_reg != '1)) begin
            addr_reg <= addr_reg + 1'b1;
        end
    end

    assign rd_addr = addr_reg;

    // Delayed read strobe/address line up with rd_data's one-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d_reg <= 1'b0;
            addr_d_reg  <= '0;
        end else begin
            valid_d_reg <= rd_en;
            addr_d_reg  <= rd_addr;
        end
    end

    assign thr_cfg[0] = cfg_lo_cnt;
    assign thr_cfg[1] = cfg_hi_cnt;

    always_comb begin
        cum_next = cum_reg;
        if (accept) begin
            cum_next = '0;
        end else if (valid_d_reg) begin
            cum_next = cum_reg + CW'(rd_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cum_reg <= '0;
        end else begin
            cum_reg <= cum_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_thresh
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    thr_reg[gi] <= '0;
                end else if (accept) begin
                    thr_reg[gi] <= thr_cfg[gi];
                end
            end

            hist_thresh_find #(
                .BITS (BITS),
                .CW   (CW)
            ) u_find (
                .clk     (clk),
                .rst_n   (rst_n),
                .clear   (accept),
                .valid   (valid_d_reg),
                .bin_idx (addr_d_reg),
                .cum     (cum_next),
                .thresh  (thr_reg[gi]),
                .result  (bin_result[gi])
            );
        end
    endgenerate

    // Results are captured on the edge entering DONE, folding in the last bin,
    // so they are already valid in the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_reg  <= '0;
            lo_bin_reg <= '0;
            hi_bin_reg <= '0;
        end else if (state_reg == ST_DRAIN) begin
            total_reg  <= cum_next;
            lo_bin_reg <= bin_result[0];
            hi_bin_reg <= bin_result[1];
        end
    end

    assign total  = total_reg;
    assign lo_bin = lo_bin_reg;
    assign hi_bin = hi_bin_reg;

`ifdef HIST_READER_MEAN_EN
    logic [MW-1:0] mac_reg, mac_next;
    logic [MW-1:0] mean_sum_reg;

    always_comb begin
        mac_next = mac_reg;
        if (accept) begin
            mac_next = '0;
        end else if (valid_d_reg) begin
            mac_next = mac_reg + MW'(addr_d_reg) * MW'(rd_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_reg      <= '0;
            mean_sum_reg <= '0;
        end else begin
            mac_reg <= mac_next;
            if (state_reg == ST_DRAIN) begin
                mean_sum_reg <= mac_next;
            end
        end
    end

    assign mean_sum = mean_sum_reg;
`else
    assign mean_sum = '0;
`endif

endmodule

// File: tb/tb_hist_reader.sv
// Randomized and directed checks of hist_reader against a behavioural
// histogram model (BITS=5, HIST_BITS=4).
module tb_hist_reader;

    localparam int BITS = 5;
    localparam int HB   = 4;
    localparam int N    = 1 << BITS;
    localparam int CW   = HB + BITS;
    localparam int MW   = HB + 2 * BITS;
`ifdef HIST_READER_MEAN_EN
    localparam bit MEAN_ON = 1'b1;
`else
    localparam bit MEAN_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [CW-1:0]   cfg_lo_cnt = '0;
    logic [CW-1:0]   cfg_hi_cnt = '0;
    logic            rd_en;
    logic [BITS-1:0] rd_addr;
    logic [HB-1:0]   rd_data = '0;
    logic            busy, done;
    logic [CW-1:0]   total;
    logic [BITS-1:0] lo_bin, hi_bin;
    logic [MW-1:0]   mean_sum;

    logic [HB-1:0]   mem [N];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    hist_reader #(.BITS(BITS), .HIST_BITS(HB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_lo_cnt (cfg_lo_cnt),
        .cfg_hi_cnt (cfg_hi_cnt),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .total      (total),
        .lo_bin     (lo_bin),
        .hi_bin     (hi_bin),
        .mean_sum   (mean_sum)
    );

    // Reference: smallest i with inclusive prefix sum > threshold, else N-1.
    task automatic model(input int lo_t, input int hi_t, output int tot,
                         output int lo, output int hi, output int mean);
        int cum;
        cum = 0; tot = 0; mean = 0; lo = N - 1; hi = N - 1;
        for (int i = N - 1; i >= 0; i--) tot += int'(mem[i]);
        for (int i = 0; i < N; i++) begin
            cum  += int'(mem[i]);
            mean += i * int'(mem[i]);
            if (cum > lo_t && lo == N - 1 && (i == 0 || cum - int'(mem[i]) <= lo_t)) lo = i;
            if (cum > hi_t && hi == N - 1 && (i == 0 || cum - int'(mem[i]) <= hi_t)) hi = i;
        end
        if (!MEAN_ON) mean = 0;
    endtask

    // Pulses start and waits for done; lat = cycles from the start edge.
    task automatic run_sweep(input int lo_t, input int hi_t, output int lat, output int rd_cnt);
        @(negedge clk);
        cfg_lo_cnt = CW'(lo_t);
        cfg_hi_cnt = CW'(hi_t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        rd_cnt = 0;
        while (lat < 100 && !done) begin
            if (rd_en) rd_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if ({rd_en, rd_addr, busy, done, total, lo_bin, hi_bin, mean_sum} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got en=%0b addr=%0d busy=%0b done=%0b tot=%0d lo=%0d hi=%0d mean=%0d, want all 0",
                     rd_en, rd_addr, busy, done, total, lo_bin, hi_bin, mean_sum);
        end
        $display("reset: outputs en=%0b busy=%0b tot=%0d", rd_en, busy, total);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_results(input string name, input int e_tot, input int e_lo,
                                 input int e_hi, input int e_mean);
        n_cmp++;
        if (total !== CW'(e_tot) || lo_bin !== BITS'(e_lo) || hi_bin !== BITS'(e_hi) || mean_sum !== MW'(e_mean)) begin
            n_err++;
            $display("FAIL %s: got tot=%0d lo=%0d hi=%0d mean=%0d, want tot=%0d lo=%0d hi=%0d mean=%0d",
                     name, total, lo_bin, hi_bin, mean_sum, e_tot, e_lo, e_hi, e_mean);
        end
        $display("%s: tot=%0d lo=%0d hi=%0d mean=%0d", name, total, lo_bin, hi_bin, mean_sum);
    endtask

    task automatic test_uniform;
        int lat, rd_cnt;
        for (int i = 0; i < N; i++) mem[i] = 4'd10;
        run_sweep(25, 295, lat, rd_cnt);
        n_cmp++;
        if (lat !== N + 2) begin
            n_err++;
            $display("FAIL uniform_latency: got %0d cycles, want %0d", lat, N + 2);
        end
        n_cmp++;
        if (rd_cnt !== N || busy !== 1'b1 || rd_addr !== BITS'(N - 1)) begin
            n_err++;
            $display("FAIL uniform_handshake: got rd_cycles=%0d busy=%0b addr=%0d, want %0d 1 %0d",
                     rd_cnt, busy, rd_addr, N, N - 1);
        end
        check_results("uniform", 320, 2, 29, MEAN_ON ? 4960 : 0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL uniform_done_pulse: got done=%0b busy=%0b a cycle later, want 0 0", done, busy);
        end
    endtask

    task automatic test_boundary;
        int lat, rd_cnt;
        run_sweep(20, 0, lat, rd_cnt);
        check_results("boundary", 320, 2, 0, MEAN_ON ? 4960 : 0);
    endtask

    task automatic test_empty;
        int lat, rd_cnt;
        for (int i = 0; i < N; i++) mem[i] = '0;
        run_sweep(0, 0, lat, rd_cnt);
        check_results("empty", 0, 31, 31, 0);
    endtask

    task automatic test_single;
        int lat, rd_cnt;
        for (int i = 0; i < N; i++) mem[i] = '0;
        mem[7] = 4'd15;
        run_sweep(0, 14, lat, rd_cnt);
        check_results("single_bin", 15, 7, 7, MEAN_ON ? 105 : 0);
    endtask

    task automatic test_back_to_back;
        int c, rd_cnt, dn_cnt, lat;
        for (int i = 0; i < N; i++) mem[i] = 4'd10;
        @(negedge clk);
        cfg_lo_cnt = CW'(25);
        cfg_hi_cnt = CW'(295);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1; rd_cnt = 0; dn_cnt = 0;
        while (c <= N + 2) begin
            if (rd_en) rd_cnt++;
            if (done) dn_cnt++;
            if (c == 10) start = 1'b1;
            if (c == 11) start = 1'b0;
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (rd_cnt !== N || dn_cnt !== 1) begin
            n_err++;
            $display("FAIL b2b_ignore: got rd_cycles=%0d dones=%0d, want %0d 1", rd_cnt, dn_cnt, N);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (rd_en !== 1'b1 || rd_addr !== '0) begin
            n_err++;
            $display("FAIL b2b_restart: got en=%0b addr=%0d, want 1 0", rd_en, rd_addr);
        end
        lat = 1;
        while (lat < 100 && !done) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== N + 2) begin
            n_err++;
            $display("FAIL b2b_latency: got %0d, want %0d", lat, N + 2);
        end
        check_results("b2b_second", 320, 2, 29, MEAN_ON ? 4960 : 0);
    endtask

    task automatic test_reset_mid;
        int c, dn_cnt, lat, rd_cnt;
        for (int i = 0; i < N; i++) mem[i] = 4'd10;
        @(negedge clk);
        cfg_lo_cnt = CW'(25);
        cfg_hi_cnt = CW'(295);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (c = 1; c < 15; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rd_en, rd_addr, busy, done, total, lo_bin, hi_bin, mean_sum} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got en=%0b addr=%0d busy=%0b tot=%0d lo=%0d hi=%0d mean=%0d, want all 0",
                     rd_en, rd_addr, busy, total, lo_bin, hi_bin, mean_sum);
        end
        dn_cnt = 0;
        for (c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (done) dn_cnt++;
        end
        n_cmp++;
        if (dn_cnt !== 0) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d done pulses, want 0", dn_cnt);
        end
        run_sweep(25, 295, lat, rd_cnt);
        n_cmp++;
        if (lat !== N + 2) begin
            n_err++;
            $display("FAIL reset_resweep_latency: got %0d, want %0d", lat, N + 2);
        end
        check_results("reset_resweep", 320, 2, 29, MEAN_ON ? 4960 : 0);
    endtask

    task automatic test_random;
        int lat, rd_cnt, e_tot, e_lo, e_hi, e_mean, lo_t, hi_t, tot_guess;
        for (int it = 0; it < 6; it++) begin
            tot_guess = 0;
            for (int i = 0; i < N; i++) begin
                mem[i] = (it == 5 && i < 20) ? 4'd0 : HB'($urandom_range(0, 15));
                tot_guess += int'(mem[i]);
            end
            lo_t = $urandom_range(0, tot_guess + 4);
            hi_t = $urandom_range(0, tot_guess + 4);
            model(lo_t, hi_t, e_tot, e_lo, e_hi, e_mean);
            run_sweep(lo_t, hi_t, lat, rd_cnt);
            n_cmp++;
            if (lat !== N + 2) begin
                n_err++;
                $display("FAIL random_latency: got %0d, want %0d", lat, N + 2);
            end
            check_results($sformatf("random%0d lo_t=%0d hi_t=%0d", it, lo_t, hi_t), e_tot, e_lo, e_hi, e_mean);
        end
    endtask

    initial begin
        test_reset;
        test_uniform;
        test_boundary;
        test_empty;
        test_single;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hist_reader.md
# hist_reader

Histogram readout engine for the ISP statistics path. It is the read-side master of `hist_stat`'s output port. After each frame it sweeps every bin, forms the pixel total, and finds the low and high percentile bins from absolute count thresholds. Results go to the AE / contrast-stretch logic and software registers.

## Interface
- `BITS`, 8: bin address width; number of bins N = 2^BITS
- `HIST_BITS`, 18: width of one bin count
- `clk`  in  1: pixel/stat clock, same domain as the `hist_stat` read port
- `rst_n`  in  1: asynchronous, active-low reset
- `start`  in  1: single-cycle pulse requesting one sweep (frame done)
- `cfg_lo_cnt`  in  HIST_BITS+BITS: low-percentile count threshold
- `cfg_hi_cnt`  in  HIST_BITS+BITS: high-percentile count threshold
- `rd_en`  out  1: read enable to `hist_stat` `out_en`
- `rd_addr`  out  BITS: bin address to `hist_stat` `out_addr`
- `rd_data`  in  HIST_BITS: bin count from `hist_stat` `out_data`; valid 1 cycle after `rd_en`
- `busy`  out  1: sweep in progress
- `done`  out  1: single-cycle pulse; results valid from this cycle
- `total`  out  HIST_BITS+BITS: sum of all bins
- `lo_bin`  out  BITS: smallest i with cum(i) > `cfg_lo_cnt`
- `hi_bin`  out  BITS: smallest i with cum(i) > `cfg_hi_cnt`
- `mean_sum`  out  HIST_BITS+2*BITS: Σ i·count(i), when enabled

## Operation
- cum(i) = Σ count(0..i), inclusive. Arithmetic is exact and unsigned; widths are sized so the sums cannot overflow.
- FSM states:
  - IDLE: `start` → READ.
  - READ: issues N reads at addresses 0..N-1, one per cycle. After address N-1 → DRAIN.
  - DRAIN: accumulates the last returned word → DONE.
  - DONE: registers the outputs, pulses `done` → IDLE.
- Accumulation runs on a delayed copy of `rd_en`/`rd_addr`, matching the 1-cycle read latency.
- Threshold search, performed separately for lo and hi:
  - A "found" flag clears at sweep start.
  - On the first returned bin where the running cum exceeds the threshold, the flag sets and that bin index is latched.
- If a threshold is never exceeded (including an empty histogram), the result is N-1.
- `start` while `busy` is ignored.
- `cfg_*` are sampled on the accepted `start` and held internally for the sweep.
- Outputs `total`, `lo_bin`, `hi_bin`, `mean_sum` update only in DONE and hold until the next DONE.
- `rd_addr` holds its last value when `rd_en` = 0.

## Timing
- `start` is sampled at edge t0.
- `rd_en` = 1 for cycles t0+1 … t0+N, with `rd_addr` = k in cycle t0+1+k.
- `rd_data` for address k is consumed in cycle t0+2+k.
- `done` pulses in cycle t0+N+2; latency from `start` to `done` is N+2 cycles.
- `busy` = 1 from t0+1 through t0+N+2 inclusive. A `start` in cycle t0+N+3 is accepted, so back-to-back sweeps are possible.
- Reset values: `rd_en`, `rd_addr`, `busy`, `done`, `total`, `lo_bin`, `hi_bin`, `mean_sum` are all 0, and the FSM is in IDLE.
- Reset mid-sweep aborts immediately: no `done` and no partial results.
- The sweep must complete before the next frame's vsync clears `hist_stat`. The system guarantees N+2 cycles ≤ vertical blanking.

## Configuration
- `HIST_READER_MEAN_EN` defined: a multiply-accumulate of bin index × count produces `mean_sum`, updated with the other results.
- `HIST_READER_MEAN_EN` undefined: the MAC logic is removed and `mean_sum` is tied to 0. All other behaviour and timing are identical.

## Structure
- Shared package `hist_pkg` holds:
  - FSM state encodings (IDLE, READ, DRAIN, DONE)
  - width helpers: count-sum width = HIST_BITS+BITS; mean width = HIST_BITS+2*BITS
- Sub-module `hist_thresh_find`, instantiated twice (lo and hi). It contains the found flag, the compare of cum against the threshold, and the bin latch with N-1 default.

## Test plan
All scenarios use BITS=5, HIST_BITS=4, with a behavioural histogram memory that has 1-cycle read latency.
1. Uniform histogram of 10 per bin; `cfg_lo_cnt`=25, `cfg_hi_cnt`=295 → `total`=320, `lo_bin`=2, `hi_bin`=29, `mean_sum`=4960. `done` arrives exactly 34 cycles after `start`.
2. Boundary: same histogram with `cfg_lo_cnt`=20, `cfg_hi_cnt`=0 → `lo_bin`=2 (cum(1)=20 is not >20), `hi_bin`=0.
3. Empty histogram (all bins 0) → `total`=0, `lo_bin`=`hi_bin`=31, `mean_sum`=0.
4. Single bin 7 = 15, rest 0; `cfg_lo_cnt`=0, `cfg_hi_cnt`=14 → `lo_bin`=`hi_bin`=7, `total`=15, `mean_sum`=105 (0 if the macro is undefined).
5. Second `start` at t0+10 → ignored: exactly one `done`, and `rd_en` is high for exactly 32 cycles. A `start` at t0+35 begins a new sweep.
6. `rst_n` asserted at t0+15 → all outputs 0 immediately and no `done`. After release, a fresh `start` gives the scenario-1 results.
